// File: rtl/ioctl_text_paste.sv
// ---------------------------------------------------------------------------
// ioctl_text_paste
//
// Purpose:
//   Captures an ASCII file sent over the data_io download channel into an
//   on-chip byte buffer, then replays it to the core as paced keystrokes.
//   During replay, line endings are normalised to a single CR, lower case
//   is folded to upper case, and unprintable bytes are dropped. Each key is
//   offered with a held strobe until the core acknowledges it. After each
//   key there is a quiet gap, which is longer after a CR so that the target
//   can process the line.
//
// Configuration:
//   TEXT_PASTE_ACK_TIMEOUT_EN - when defined, a key that has not been
//   acknowledged after ACK_TIMEOUT cycles is dropped. Playback then
//   continues as if the key had been acked. When undefined, OFFER waits
//   indefinitely and no timeout counter exists.
//
// Ports:
//   clk_sys         in   1   system clock
//   reset           in   1   synchronous, active-high reset
//   ioctl_download  in   1   data_io download active
//   ioctl_index     in   8   download file index
//   ioctl_wr        in   1   byte-write strobe, one cycle
//   ioctl_addr      in   25  byte address in file
//   ioctl_dout      in   8   file byte
//   abort           in   1   one-cycle request: stop playback, discard buffer
//   key_data        out  7   ASCII code offered to the core
//   key_strobe      out  1   key_data valid; held until key_ack
//   key_ack         in   1   one-cycle pulse: core consumed key_data
//   busy            out  1   high while loading or playing back
//   overflow        out  1   sticky: last file exceeded the buffer
//   dbg_state       out  3   current FSM state (debug visibility)
//
// Key handshake:
//   key_strobe rises together with a new key_data. Both are held stable
//   until a cycle in which key_ack is sampled high. key_strobe drops on the
//   following cycle. A key_ack seen while key_strobe is low is ignored.
//
// DEPTH_LOG2 must be in the range 1..24.
// ---------------------------------------------------------------------------
module ioctl_text_paste #(
    parameter int         DEPTH_LOG2  = 13,
    parameter logic [7:0] INDEX       = 8'd1,
    parameter int         CHAR_DELAY  = 25000,
    parameter int         CR_DELAY    = 250000,
    parameter int         ACK_TIMEOUT = 2500000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        abort,
    output logic [6:0]  key_data,
    output logic        key_strobe,
    input  logic        key_ack,
    output logic        busy,
    output logic        overflow,
    output logic [2:0]  dbg_state
);

    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int LW       = DEPTH_LOG2 + 1;          // length can equal DEPTH
    localparam int PACE_MAX = (CR_DELAY > CHAR_DELAY) ? CR_DELAY : CHAR_DELAY;
    localparam int PW       = (PACE_MAX < 1) ? 1 : $clog2(PACE_MAX + 1);
    localparam logic [PW-1:0] CHAR_LD = CHAR_DELAY[PW-1:0];
    localparam logic [PW-1:0] CR_LD   = CR_DELAY[PW-1:0];

`ifdef TEXT_PASTE_ACK_TIMEOUT_EN
    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int TO_LAST_I = (ACK_TIMEOUT < 1) ? 0 : ACK_TIMEOUT - 1;
    localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_XLATE = 3'd3,
        S_OFFER = 3'd4,
        S_PACE  = 3'd5
    } state_t;

    // Only the low seven bits of each byte are ever used, so only those are stored.
    logic [6:0]    r_ram [DEPTH];
    logic [6:0]    r_rd_data;

    state_t        r_state;
    logic          r_sel_q;
    logic [LW-1:0] r_length;
    logic [LW-1:0] r_rd_ptr;
    logic          r_prev_cr;
    logic [PW-1:0] r_pace;
    logic [6:0]    r_key_data;
    logic          r_key_strobe;
    logic          r_overflow;
`ifdef TEXT_PASTE_ACK_TIMEOUT_EN
    logic [TW-1:0] r_to_cnt;
`endif

    logic          w_sel;
    logic          w_sel_rise;
    logic          w_enter_load;
    logic          w_addr_in_range;
    logic [LW-1:0] w_addr_p1;
    logic          w_wr_ok;
    logic          w_ram_we;
    logic          w_oflow_set;
    logic [LW-1:0] w_len_base;
    logic [LW-1:0] w_len_new;
    logic          w_abort_take;
    logic [6:0]    w_byte;
    logic [6:0]    w_char;
    logic          w_emit;
    logic          w_lf_collapse;
    logic [LW-1:0] w_ptr_next;
    logic          w_unused_dout_msb;

    assign w_unused_dout_msb = ioctl_dout[7];

    assign w_sel      = ioctl_download && (ioctl_index == INDEX);
    assign w_sel_rise = w_sel && !r_sel_q;

    // LOAD is entered from IDLE on a selected download.
    // A fresh selection edge also pre-empts any playback state.
    assign w_enter_load = w_sel && ((r_state == S_IDLE) ||
                                    ((r_state != S_LOAD) && w_sel_rise));

    // Abort is honoured outside IDLE.
    // A live selection wins over abort, both when entering LOAD and while in it.
    assign w_abort_take = abort && (r_state != S_IDLE) && !w_enter_load &&
                          !((r_state == S_LOAD) && w_sel);

    assign w_addr_in_range = (ioctl_addr[24:DEPTH_LOG2] == '0);
    assign w_addr_p1       = {1'b0, ioctl_addr[DEPTH_LOG2-1:0]} + LW'(1);

    // A write on the LOAD-entry cycle is accepted, so an early first byte is not lost.
    assign w_wr_ok     = ioctl_wr && w_sel && ((r_state == S_LOAD) || w_enter_load);
    assign w_ram_we    = w_wr_ok && w_addr_in_range;
    assign w_oflow_set = w_wr_ok && !w_addr_in_range;
    assign w_len_base  = w_enter_load ? '0 : r_length;
    assign w_len_new   = (w_ram_we && (w_addr_p1 > w_len_base)) ? w_addr_p1 : w_len_base;

    assign w_byte     = r_rd_data;
    assign w_ptr_next = r_rd_ptr + LW'(1);

    // Character translation.
    // An LF directly after an emitted CR is collapsed and keeps prev_cr set,
    // so that CR LF produces exactly one CR key.
    always_comb begin
        w_emit        = 1'b1;
        w_char        = w_byte;
        w_lf_collapse = 1'b0;
        if (w_byte == 7'h0A) begin
            if (r_prev_cr) begin
                w_emit        = 1'b0;
                w_lf_collapse = 1'b1;
            end else begin
                w_char = 7'h0D;
            end
        end else if (w_byte == 7'h0D) begin
            w_char = 7'h0D;
        end else if ((w_byte >= 7'h61) && (w_byte <= 7'h7A)) begin
            w_char = w_byte - 7'h20;
        end else if ((w_byte < 7'h20) || (w_byte == 7'h7F)) begin
            w_emit = 1'b0;
        end
    end

    // Buffer RAM: one write port driven by data_io.
    // One synchronous read port follows rd_ptr, so data is valid the cycle after FETCH.
    always_ff @(posedge clk_sys) begin
        if (w_ram_we) begin
            r_ram[ioctl_addr[DEPTH_LOG2-1:0]] <= ioctl_dout[6:0];
        end
        r_rd_data <= r_ram[r_rd_ptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sel_q      <= 1'b0;
            r_length     <= '0;
            r_rd_ptr     <= '0;
            r_prev_cr    <= 1'b0;
            r_pace       <= '0;
            r_key_data   <= '0;
            r_key_strobe <= 1'b0;
            r_overflow   <= 1'b0;
`ifdef TEXT_PASTE_ACK_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_sel_q <= w_sel;
            if (w_enter_load) begin
                r_state      <= S_LOAD;
                r_key_strobe <= 1'b0;
                r_length     <= w_len_new;
                r_overflow   <= w_oflow_set;
            end else if (w_abort_take) begin
                r_state      <= S_IDLE;
                r_key_strobe <= 1'b0;
                r_length     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_LOAD: begin
                        r_length <= w_len_new;
                        if (w_oflow_set) begin
                            r_overflow <= 1'b1;
                        end
                        if (!w_sel) begin
                            if (r_length == '0) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_rd_ptr  <= '0;
                                r_prev_cr <= 1'b0;
                                r_state   <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        r_state <= S_XLATE;
                    end
                    S_XLATE: begin
                        r_rd_ptr <= w_ptr_next;
                        if (w_emit) begin
                            r_key_data   <= w_char;
                            r_key_strobe <= 1'b1;
                            r_prev_cr    <= (w_char == 7'h0D);
`ifdef TEXT_PASTE_ACK_TIMEOUT_EN
                            r_to_cnt     <= '0;
`endif
                            r_state      <= S_OFFER;
                        end else begin
                            r_prev_cr <= w_lf_collapse;
                            r_state   <= (w_ptr_next == r_length) ? S_IDLE : S_FETCH;
                        end
                    end
                    S_OFFER: begin
                        if (key_ack) begin
                            r_key_strobe <= 1'b0;
                            r_pace       <= (r_key_data == 7'h0D) ? CR_LD : CHAR_LD;
                            r_state      <= S_PACE;
`ifdef TEXT_PASTE_ACK_TIMEOUT_EN
                        end else if (r_to_cnt == TO_LAST) begin
                            // Unacknowledged key: drop it and pace as for a normal character.
                            r_key_strobe <= 1'b0;
                            r_pace       <= CHAR_LD;
                            r_state      <= S_PACE;
                        end else begin
                            r_to_cnt <= r_to_cnt + TW'(1);
`endif
                        end
                    end
                    S_PACE: begin
                        if (r_pace == '0) begin
                            r_state <= (r_rd_ptr == r_length) ? S_IDLE : S_FETCH;
                        end else begin
                            r_pace <= r_pace - PW'(1);
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_key_strobe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_data   = r_key_data;
    assign key_strobe = r_key_strobe;
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ioctl_text_paste.sv
// ---------------------------------------------------------------------------
// tb_ioctl_text_paste
//
// Directed bench for ioctl_text_paste.
// The DUT is built with a 16-byte buffer and short pacing delays
// (CHAR_DELAY=5, CR_DELAY=20), so every scenario stays a few hundred cycles long.
//
// Expected keys are queued in exp_q and consumed as the DUT offers them.
// Gap figures are counted in negedges from the one that raises key_ack:
//   ack -> next strobe  = delay + 4   (PACE delay+1 cycles, FETCH, XLATE, sample)
//   ack -> busy low     = delay + 2
// ---------------------------------------------------------------------------
module tb_ioctl_text_paste;

    localparam int DEPTH_LOG2  = 4;
    localparam int CHAR_DELAY  = 5;
    localparam int CR_DELAY    = 20;
    localparam int ACK_TIMEOUT = 100;

    // ---------------- clock / reset ----------------
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        abort = 1'b0;
    logic        key_ack = 1'b0;
    logic [6:0]  key_data;
    logic        key_strobe;
    logic        busy;
    logic        overflow;
    logic [2:0]  dbg_state;

    always #5 clk_sys = ~clk_sys;

    ioctl_text_paste #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INDEX      (8'd1),
        .CHAR_DELAY (CHAR_DELAY),
        .CR_DELAY   (CR_DELAY),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .abort         (abort),
        .key_data      (key_data),
        .key_strobe    (key_strobe),
        .key_ack       (key_ack),
        .busy          (busy),
        .overflow      (overflow),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail = 0;
    logic [6:0] exp_q[$];
    logic [7:0] dl_bytes[$];
    int         gaps[$];
    logic       dl_busy_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Writes dl_bytes to consecutive addresses starting at start_addr, then drops download.
    task automatic download(input logic [7:0] idx, input int start_addr);
        dl_busy_seen = 1'b0;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        repeat (2) begin
            @(negedge clk_sys);
            dl_busy_seen |= busy | key_strobe;
        end
        for (int i = 0; i < dl_bytes.size(); i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(start_addr + i);
            ioctl_dout = dl_bytes[i];
            @(negedge clk_sys);
            dl_busy_seen |= busy | key_strobe;
            ioctl_wr = 1'b0;
            @(negedge clk_sys);
            dl_busy_seen |= busy | key_strobe;
        end
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (key_strobe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    // Pulses key_ack, then counts negedges until the next strobe or until idle.
    task automatic ack_measure(input string tag, output int gap);
        key_ack = 1'b1;
        @(negedge clk_sys);
        key_ack = 1'b0;
        gap = 1;
        check({tag, "_strobe_drop"}, key_strobe, 1'b0);
        while (!key_strobe && busy && gap < 1000) begin
            @(negedge clk_sys);
            gap++;
        end
    endtask

    // Drains exp_q against the DUT, acking each key three cycles after it appears.
    task automatic play(input string tag);
        bit         ok;
        int         gap;
        logic [6:0] e;
        gaps.delete();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_strobe(ok);
            check({tag, "_strobe"}, ok, 1'b1);
            if (!ok) begin
                exp_q.delete();
                break;
            end
            check({tag, "_key"}, key_data, e);
            repeat (3) @(negedge clk_sys);
            check({tag, "_hold"}, {key_strobe, key_data}, {1'b1, e});
            ack_measure(tag, gap);
            gaps.push_back(gap);
        end
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_strobe"}, key_strobe, 1'b0);
    endtask

    // Bound on the whole run.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        bit ok;
        int gap;
        int stray;

        // Reset state
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_key_data", key_data, 7'h00);
        check("rst_strobe", key_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_state", dbg_state, 3'd0);

        // 1: "ab\n" -> 41 42 0D.  Gaps: 5+4, 5+4, then busy low 20+2 after the CR ack.
        dl_bytes = '{8'h61, 8'h62, 8'h0A};
        download(8'd1, 0);
        check("t1_busy_load", dl_busy_seen, 1'b1);
        exp_q = '{7'h41, 7'h42, 7'h0D};
        play("t1");
        if (gaps.size() == 3) begin
            check("t1_gap_a", gaps[0], 9);
            check("t1_gap_b", gaps[1], 9);
            check("t1_gap_cr", gaps[2], 22);
        end else begin
            check("t1_gap_count", gaps.size(), 3);
        end

        // 2a: "X\r\nY" -> 58 0D 59 (CR LF collapsed)
        dl_bytes = '{8'h58, 8'h0D, 8'h0A, 8'h59};
        download(8'd1, 0);
        exp_q = '{7'h58, 7'h0D, 7'h59};
        play("t2a");

        // 2b: 09 7F C1 -> 41 only
        dl_bytes = '{8'h09, 8'h7F, 8'hC1};
        download(8'd1, 0);
        exp_q = '{7'h41};
        play("t2b");

        // 3: 20-byte file into a 16-byte buffer: overflow, first 16 bytes played
        dl_bytes.delete();
        for (int i = 0; i < 20; i++) dl_bytes.push_back(8'(8'h41 + i));
        download(8'd1, 0);
        @(negedge clk_sys);
        check("t3_overflow", overflow, 1'b1);
        for (int i = 0; i < 16; i++) exp_q.push_back(7'(7'h41 + i));
        play("t3");
        check("t3_overflow_sticky", overflow, 1'b1);
        dl_bytes = '{8'h51};
        download(8'd1, 0);
        check("t3_overflow_clear", overflow, 1'b0);
        exp_q = '{7'h51};
        play("t3b");

        // 4: index 2 download must not change state or RAM.
        // A later 1-byte index-1 file at address 1 then replays the old byte 0 ('Q').
        dl_bytes = '{8'h4D, 8'h4D};
        download(8'd2, 0);
        stray = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (busy || key_strobe) stray++;
        end
        check("t4_busy_during", dl_busy_seen, 1'b0);
        check("t4_stray_after", stray, 0);
        dl_bytes = '{8'h4E};
        download(8'd1, 1);
        exp_q = '{7'h51, 7'h4E};
        play("t4");

        // 5: abort during PACE of the 2nd char of "HELLO"
        dl_bytes = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        download(8'd1, 0);
        wait_strobe(ok);
        check("t5_key0", {ok, key_data}, {1'b1, 7'h48});
        repeat (3) @(negedge clk_sys);
        ack_measure("t5a", gap);
        check("t5_key1", {key_strobe, key_data}, {1'b1, 7'h45});
        repeat (3) @(negedge clk_sys);
        key_ack = 1'b1;
        @(negedge clk_sys);
        key_ack = 1'b0;
        @(negedge clk_sys);
        check("t5_in_pace", dbg_state, 3'd5);
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_strobe", key_strobe, 1'b0);
        stray = 0;
        repeat (30) begin
            @(negedge clk_sys);
            if (busy || key_strobe) stray++;
        end
        check("t5_quiet", stray, 0);
        dl_bytes = '{8'h5A};
        download(8'd1, 0);
        exp_q = '{7'h5A};
        play("t5");

        // 6: a new selected download during OFFER abandons playback
        dl_bytes = '{8'h41, 8'h42};
        download(8'd1, 0);
        wait_strobe(ok);
        check("t6_key0", {ok, key_data}, {1'b1, 7'h41});
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        @(negedge clk_sys);
        check("t6_strobe_drop", key_strobe, 1'b0);
        check("t6_state_load", dbg_state, 3'd1);
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        @(negedge clk_sys);
        dl_bytes = '{8'h4B};
        download(8'd1, 0);
        exp_q = '{7'h4B};
        play("t6");

        // 7: reset mid-OFFER with overflow set clears every output in one cycle
        dl_bytes.delete();
        for (int i = 0; i < 17; i++) dl_bytes.push_back(8'(8'h41 + i));
        download(8'd1, 0);
        wait_strobe(ok);
        check("t7_pre", {ok, overflow, key_data}, {1'b1, 1'b1, 7'h41});
        reset = 1'b1;
        @(negedge clk_sys);
        check("t7_rst_outs", {key_strobe, busy, overflow, key_data}, 10'd0);
        reset = 1'b0;
        @(negedge clk_sys);

`ifdef TEXT_PASTE_ACK_TIMEOUT_EN
        // 8: no acks: each key is held for ACK_TIMEOUT cycles, then dropped
        dl_bytes = '{8'h41, 8'h42};
        download(8'd1, 0);
        for (int k = 0; k < 2; k++) begin
            int hi;
            wait_strobe(ok);
            check("t8_key", {ok, key_data}, {1'b1, 7'(7'h41 + k)});
            hi = 0;
            while (key_strobe && hi < 1000) begin
                hi++;
                @(negedge clk_sys);
            end
            check("t8_hold_cycles", hi, ACK_TIMEOUT);
        end
        repeat (CHAR_DELAY + 3) @(negedge clk_sys);
        check("t8_idle", {busy, key_strobe}, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
